// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: one outstanding imem read per PC, result parked in a
// one-entry IF/ID slot; redirects flush the slot and discard wrong-path responses.
module ifetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc4,
  output logic              pc_stop,
  input  logic              redirect,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready
);

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT
  } state_t;

  state_t            state_q;
  logic              rst_q;
  logic              drop_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              id_valid_q;
  logic [ADDR_W-1:0] id_pc_q;
  logic [INST_W-1:0] id_inst_q;

  logic              id_valid_d;
  logic [ADDR_W-1:0] id_pc_d;
  logic [INST_W-1:0] id_inst_d;

  logic              in_boot;
  logic              slot_free;
  logic              req_valid;
  logic              fire;
  logic              fill;

  // The PC register resets one cycle late, so stay quiet while either rst or rst_q is up.
  assign in_boot   = rst || rst_q || (state_q == BOOT);
  assign slot_free = !id_valid_q || id_ready;
  assign req_valid = !in_boot && (state_q == REQ) && slot_free;
  assign fire      = req_valid && imem_req_ready;
  assign fill      = !in_boot && (state_q == WAIT) && imem_resp_valid && !drop_q && !redirect;

  assign pc4            = pc_in + {{(ADDR_W-3){1'b0}}, 3'd4};
  assign pc_stop        = in_boot ? 1'b1 : !(fire || redirect);
  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_in;
  assign id_valid       = id_valid_q;
  assign id_pc          = id_pc_q;
  assign id_inst        = id_inst_q;

  // Redirect beats fill beats consume; an empty slot always shows NOP_INST.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    if (redirect) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end else if (fill) begin
      id_valid_d = 1'b1;
      id_pc_d    = req_pc_q;
      id_inst_d  = imem_resp_data;
    end else if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst || rst_q) begin
      state_q    <= BOOT;
      drop_q     <= 1'b0;
      req_pc_q   <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      case (state_q)
        BOOT: state_q <= REQ;
        REQ: begin
          if (fire) begin
            state_q  <= WAIT;
            req_pc_q <= pc_in;
            drop_q   <= redirect;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            state_q <= REQ;
            drop_q  <= 1'b0;
          end else if (redirect) begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: bench-side PC register and fixed-latency imem responder,
// expected values hand-derived per cycle.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] pc4;
  logic        pc_stop;
  logic        redirect;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;

  localparam logic [31:0] NOP = 32'h00000013;

  int          vecs;
  int          errs;
  logic [31:0] target;
  int          lat;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  ifetch_unit #(
    .ADDR_W  (32),
    .INST_W  (32),
    .NOP_INST(32'h00000013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc4            (pc4),
    .pc_stop        (pc_stop),
    .redirect       (redirect),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_ready       (id_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock cycle: PC register and memory models advance; redirect is a one-cycle pulse.
  task automatic step();
    logic        f;
    logic [31:0] a;
    logic [31:0] nxt;
    #1;
    f = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    if (rst) nxt = 32'h0;
    else if (!pc_stop) nxt = redirect ? target : pc_in + 32'd4;
    else nxt = pc_in;
    @(posedge clk);
    #1;
    pc_in           = nxt;
    redirect        = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if (f) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = a;
    end
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = {16'hC0DE, paddr[15:0]};
        pend            = 1'b0;
      end
    end
  endtask

  // Leaves the bench on the first REQ cycle with pc_in = 0.
  task automatic do_reset();
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    id_ready        = 1'b1;
    redirect        = 1'b0;
    lat             = 1;
    pend            = 1'b0;
    imem_resp_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    #1;
  endtask

  task automatic test_pc4();
    pc_in = 32'hFFFFFFFC;
    #1;
    vecs++; if (pc4 !== 32'h0) begin errs++; $display("FAIL pc4_wrap got=%h exp=00000000", pc4); end
    pc_in = 32'h00001234;
    #1;
    vecs++; if (pc4 !== 32'h00001238) begin errs++; $display("FAIL pc4_plain got=%h exp=00001238", pc4); end
    pc_in = 32'h0;
    $display("test_pc4 done");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    step();
    #1;
    vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
    vecs++; if (id_pc !== 32'h0) begin errs++; $display("FAIL rst_id_pc got=%h exp=0", id_pc); end
    vecs++; if (id_inst !== NOP) begin errs++; $display("FAIL rst_id_inst got=%h exp=%h", id_inst, NOP); end
    vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    vecs++; if (pc_stop !== 1'b1) begin errs++; $display("FAIL rst_pc_stop got=%b exp=1", pc_stop); end
    rst = 1'b0;
    #1;
    vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL rel1_req_valid got=%b exp=0", imem_req_valid); end
    vecs++; if (pc_stop !== 1'b1) begin errs++; $display("FAIL rel1_pc_stop got=%b exp=1", pc_stop); end
    step();
    #1;
    vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL rel2_req_valid got=%b exp=0", imem_req_valid); end
    vecs++; if (pc_stop !== 1'b1) begin errs++; $display("FAIL rel2_pc_stop got=%b exp=1", pc_stop); end
    step();
    #1;
    vecs++; if (imem_req_valid !== 1'b1) begin errs++; $display("FAIL rel3_req_valid got=%b exp=1", imem_req_valid); end
    vecs++; if (imem_req_addr !== 32'h0) begin errs++; $display("FAIL rel3_req_addr got=%h exp=0", imem_req_addr); end
    $display("test_reset done");
  endtask

  task automatic test_fetch_seq();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'(k * 4);
      vecs++; if (imem_req_valid !== 1'b1) begin errs++; $display("FAIL seq_req_valid k=%0d got=%b exp=1", k, imem_req_valid); end
      vecs++; if (imem_req_addr !== exp_pc) begin errs++; $display("FAIL seq_req_addr k=%0d got=%h exp=%h", k, imem_req_addr, exp_pc); end
      vecs++; if (pc_stop !== 1'b0) begin errs++; $display("FAIL seq_fire_pc_stop k=%0d got=%b exp=0", k, pc_stop); end
      step();
      #1;
      vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL seq_wait_req k=%0d got=%b exp=0", k, imem_req_valid); end
      vecs++; if (pc_stop !== 1'b1) begin errs++; $display("FAIL seq_wait_pc_stop k=%0d got=%b exp=1", k, pc_stop); end
      vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL seq_wait_id_valid k=%0d got=%b exp=0", k, id_valid); end
      step();
      #1;
      vecs++; if (id_valid !== 1'b1) begin errs++; $display("FAIL seq_id_valid k=%0d got=%b exp=1", k, id_valid); end
      vecs++; if (id_pc !== exp_pc) begin errs++; $display("FAIL seq_id_pc k=%0d got=%h exp=%h", k, id_pc, exp_pc); end
      vecs++; if (id_inst !== {16'hC0DE, exp_pc[15:0]}) begin errs++; $display("FAIL seq_id_inst k=%0d got=%h exp=%h", k, id_inst, {16'hC0DE, exp_pc[15:0]}); end
    end
    $display("test_fetch_seq done");
  endtask

  task automatic test_backpressure();
    do_reset();
    step();
    step();
    step();
    id_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL bp_req_valid i=%0d got=%b exp=0", i, imem_req_valid); end
      vecs++; if (pc_stop !== 1'b1) begin errs++; $display("FAIL bp_pc_stop i=%0d got=%b exp=1", i, pc_stop); end
      vecs++; if (id_valid !== 1'b1) begin errs++; $display("FAIL bp_id_valid i=%0d got=%b exp=1", i, id_valid); end
      vecs++; if (id_pc !== 32'h4) begin errs++; $display("FAIL bp_id_pc i=%0d got=%h exp=4", i, id_pc); end
      vecs++; if (pc_in !== 32'h8) begin errs++; $display("FAIL bp_pc_in i=%0d got=%h exp=8", i, pc_in); end
      step();
    end
    id_ready = 1'b1;
    #1;
    vecs++; if (imem_req_valid !== 1'b1) begin errs++; $display("FAIL bp_release_req got=%b exp=1", imem_req_valid); end
    vecs++; if (imem_req_addr !== 32'h8) begin errs++; $display("FAIL bp_release_addr got=%h exp=8", imem_req_addr); end
    vecs++; if (pc_stop !== 1'b0) begin errs++; $display("FAIL bp_release_pc_stop got=%b exp=0", pc_stop); end
    step();
    #1;
    vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL bp_consumed got=%b exp=0", id_valid); end
    vecs++; if (id_inst !== NOP) begin errs++; $display("FAIL bp_consumed_inst got=%h exp=%h", id_inst, NOP); end
    $display("test_backpressure done");
  endtask

  task automatic test_mem_stall();
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (imem_req_valid !== 1'b1) begin errs++; $display("FAIL stall_req_valid i=%0d got=%b exp=1", i, imem_req_valid); end
      vecs++; if (imem_req_addr !== 32'h0) begin errs++; $display("FAIL stall_req_addr i=%0d got=%h exp=0", i, imem_req_addr); end
      vecs++; if (pc_stop !== 1'b1) begin errs++; $display("FAIL stall_pc_stop i=%0d got=%b exp=1", i, pc_stop); end
      step();
    end
    imem_req_ready = 1'b1;
    #1;
    vecs++; if (pc_stop !== 1'b0) begin errs++; $display("FAIL stall_fire_pc_stop got=%b exp=0", pc_stop); end
    vecs++; if (pc_in !== 32'h0) begin errs++; $display("FAIL stall_pc_held got=%h exp=0", pc_in); end
    step();
    #1;
    vecs++; if (pc_in !== 32'h4) begin errs++; $display("FAIL stall_pc_adv got=%h exp=4", pc_in); end
    vecs++; if (pc_stop !== 1'b1) begin errs++; $display("FAIL stall_wait_pc_stop got=%b exp=1", pc_stop); end
    step();
    #1;
    vecs++; if (pc_in !== 32'h4) begin errs++; $display("FAIL stall_pc_once got=%h exp=4", pc_in); end
    vecs++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin errs++; $display("FAIL stall_slot got=%b/%h exp=1/0", id_valid, id_pc); end
    $display("test_mem_stall done");
  endtask

  task automatic test_redirect_fire();
    do_reset();
    step();
    step();
    step();
    step();
    redirect = 1'b1;
    target   = 32'h100;
    #1;
    vecs++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin errs++; $display("FAIL rf_req got=%b/%h exp=1/8", imem_req_valid, imem_req_addr); end
    vecs++; if (pc_stop !== 1'b0) begin errs++; $display("FAIL rf_pc_stop got=%b exp=0", pc_stop); end
    step();
    #1;
    vecs++; if (pc_in !== 32'h100) begin errs++; $display("FAIL rf_pc_target got=%h exp=100", pc_in); end
    vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL rf_flush_valid got=%b exp=0", id_valid); end
    step();
    #1;
    vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL rf_drop_valid got=%b exp=0", id_valid); end
    vecs++; if (id_inst !== NOP) begin errs++; $display("FAIL rf_drop_inst got=%h exp=%h", id_inst, NOP); end
    vecs++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errs++; $display("FAIL rf_next_req got=%b/%h exp=1/100", imem_req_valid, imem_req_addr); end
    step();
    step();
    #1;
    vecs++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin errs++; $display("FAIL rf_target_slot got=%b/%h exp=1/100", id_valid, id_pc); end
    vecs++; if (id_inst !== 32'hC0DE0100) begin errs++; $display("FAIL rf_target_inst got=%h exp=c0de0100", id_inst); end
    $display("test_redirect_fire done");
  endtask

  task automatic test_redirect_wait();
    do_reset();
    step();
    step();
    id_ready = 1'b0;
    redirect = 1'b1;
    target   = 32'h40;
    #1;
    vecs++; if (id_valid !== 1'b1) begin errs++; $display("FAIL rw_slot_full got=%b exp=1", id_valid); end
    vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL rw_stalled_req got=%b exp=0", imem_req_valid); end
    vecs++; if (pc_stop !== 1'b0) begin errs++; $display("FAIL rw_redir_pc_stop got=%b exp=0", pc_stop); end
    step();
    id_ready = 1'b1;
    lat      = 3;
    #1;
    vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL rw_flush_valid got=%b exp=0", id_valid); end
    vecs++; if (id_inst !== NOP) begin errs++; $display("FAIL rw_flush_inst got=%h exp=%h", id_inst, NOP); end
    vecs++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin errs++; $display("FAIL rw_req40 got=%b/%h exp=1/40", imem_req_valid, imem_req_addr); end
    step();
    redirect = 1'b1;
    target   = 32'h80;
    #1;
    vecs++; if (pc_stop !== 1'b0) begin errs++; $display("FAIL rw_wait_redir_pc_stop got=%b exp=0", pc_stop); end
    vecs++; if (imem_req_valid !== 1'b0) begin errs++; $display("FAIL rw_wait_req got=%b exp=0", imem_req_valid); end
    step();
    #1;
    vecs++; if (pc_in !== 32'h80) begin errs++; $display("FAIL rw_pc_target got=%h exp=80", pc_in); end
    vecs++; if (pc_stop !== 1'b1) begin errs++; $display("FAIL rw_wait2_pc_stop got=%b exp=1", pc_stop); end
    step();
    #1;
    vecs++; if (imem_resp_valid !== 1'b1) begin errs++; $display("FAIL rw_bench_resp got=%b exp=1", imem_resp_valid); end
    lat = 1;
    step();
    #1;
    vecs++; if (id_valid !== 1'b0 || id_inst !== NOP) begin errs++; $display("FAIL rw_late_dropped got=%b/%h exp=0/%h", id_valid, id_inst, NOP); end
    vecs++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin errs++; $display("FAIL rw_req80 got=%b/%h exp=1/80", imem_req_valid, imem_req_addr); end
    step();
    step();
    #1;
    vecs++; if (id_valid !== 1'b1 || id_pc !== 32'h80 || id_inst !== 32'hC0DE0080) begin errs++; $display("FAIL rw_target_slot got=%b/%h/%h exp=1/80/c0de0080", id_valid, id_pc, id_inst); end
    $display("test_redirect_wait done");
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    lat = 3;
    step();
    rst = 1'b1;
    #1;
    vecs++; if (imem_req_valid !== 1'b0 || pc_stop !== 1'b1) begin errs++; $display("FAIL rmw_in_rst got=%b/%b exp=0/1", imem_req_valid, pc_stop); end
    step();
    step();
    rst = 1'b0;
    #1;
    vecs++; if (imem_resp_valid !== 1'b1) begin errs++; $display("FAIL rmw_bench_resp got=%b exp=1", imem_resp_valid); end
    vecs++; if (imem_req_valid !== 1'b0 || pc_stop !== 1'b1) begin errs++; $display("FAIL rmw_boot1 got=%b/%b exp=0/1", imem_req_valid, pc_stop); end
    step();
    #1;
    vecs++; if (id_valid !== 1'b0 || id_inst !== NOP) begin errs++; $display("FAIL rmw_no_fill got=%b/%h exp=0/%h", id_valid, id_inst, NOP); end
    vecs++; if (imem_req_valid !== 1'b0 || pc_stop !== 1'b1) begin errs++; $display("FAIL rmw_boot2 got=%b/%b exp=0/1", imem_req_valid, pc_stop); end
    step();
    #1;
    vecs++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errs++; $display("FAIL rmw_req0 got=%b/%h exp=1/0", imem_req_valid, imem_req_addr); end
    vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL rmw_slot_empty got=%b exp=0", id_valid); end
    lat = 1;
    $display("test_reset_mid_wait done");
  endtask

  initial begin
    vecs            = 0;
    errs            = 0;
    rst             = 1'b1;
    pc_in           = 32'h0;
    redirect        = 1'b0;
    target          = 32'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    id_ready        = 1'b1;
    lat             = 1;
    pend            = 1'b0;
    cnt             = 0;
    paddr           = 32'h0;
    test_pc4();
    test_reset();
    test_fetch_seq();
    test_backpressure();
    test_mem_stall();
    test_redirect_fire();
    test_redirect_wait();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
